// File: rtl/demux_1x8_wb.sv
// Registered 1-to-8 demultiplexer: routes one word to channel {s2,s1,s0}, each
// channel owning a one-entry holding register with its own valid/ready pair.
module demux_1x8_wb #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_data,
  input  logic         s0,
  input  logic         s1,
  input  logic         s2,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic [N-1:0] c,
  output logic [N-1:0] d,
  output logic [N-1:0] e,
  output logic [N-1:0] f,
  output logic [N-1:0] g,
  output logic [N-1:0] h,
  output logic [7:0]   out_valid,
  input  logic [7:0]   out_ready,
  output logic         busy
);

  logic [2:0]   idx;
  logic         accept;
  logic [N-1:0] chan_data [8];

  assign idx = {s2, s1, s0};

  // Only the selected channel's state gates acceptance; a full channel that is
  // draining this cycle can take a new word, giving 1 word/cycle per channel.
  assign in_ready = !rst && (!out_valid[idx] || out_ready[idx]);
  assign accept   = in_valid && in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : ch_g
      logic [N-1:0] data_reg;
      logic         valid_reg;
      logic         wr;

      assign wr = accept && (idx == 3'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg  <= '0;
          valid_reg <= 1'b0;
        end else if (wr) begin
          data_reg  <= in_data;
          valid_reg <= 1'b1;
        end else if (out_ready[gi]) begin
          valid_reg <= 1'b0;
        end
      end

      assign chan_data[gi] = data_reg;
      assign out_valid[gi] = valid_reg;
    end
  endgenerate

  assign a = chan_data[0];
  assign b = chan_data[1];
  assign c = chan_data[2];
  assign d = chan_data[3];
  assign e = chan_data[4];
  assign f = chan_data[5];
  assign g = chan_data[6];
  assign h = chan_data[7];

  assign busy = |out_valid;

endmodule

// File: tb/tb_demux_1x8_wb.sv
// Self-checking bench for demux_1x8_wb: directed scenarios plus random traffic,
// all compared against a per-channel slot model kept in plain arrays.
module tb_demux_1x8_wb;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] in_data;
  logic         s0, s1, s2;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a, b, c, d, e, f, g, h;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic         busy;

  int checks = 0;
  int errors = 0;

  // Reference: each channel is a slot that is either empty or holds one word.
  logic [N-1:0] m_data  [8];
  bit           m_full  [8];

  always #5 clk = ~clk;

  demux_1x8_wb #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_data(in_data),
    .s0(s0), .s1(s1), .s2(s2),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] dut_chan(input int k);
    case (k)
      0: return a;  1: return b;  2: return c;  3: return d;
      4: return e;  5: return f;  6: return g;  default: return h;
    endcase
  endfunction

  task automatic check_state(input string phase);
    logic [7:0] exp_valid;
    exp_valid = '0;
    for (int k = 0; k < 8; k++) begin
      exp_valid[k] = m_full[k];
      check($sformatf("%s_ch%0d", phase, k), dut_chan(k), m_data[k]);
    end
    check({phase, "_out_valid"}, {24'h0, out_valid}, {24'h0, exp_valid});
    check({phase, "_busy"}, {31'h0, busy}, {31'h0, |exp_valid});
  endtask

  // One clock cycle of stimulus; checks in_ready and that nothing has changed
  // before the edge, then advances the model and checks after the edge.
  task automatic step(input bit r, input bit v, input int sel, input logic [N-1:0] dat,
                      input logic [7:0] ordy, input string tag);
    bit exp_rdy, acc;
    rst = r; in_valid = v; {s2, s1, s0} = 3'(sel); in_data = dat; out_ready = ordy;
    #1;
    exp_rdy = !r && (!m_full[sel] || ordy[sel]);
    check({tag, "_in_ready"}, {31'h0, in_ready}, {31'h0, exp_rdy});
    check_state({tag, "_pre"});
    acc = v && exp_rdy;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      if (r) begin
        m_full[k] = 0; m_data[k] = '0;
      end else if (acc && k == sel) begin
        m_full[k] = 1; m_data[k] = dat;
      end else if (ordy[k]) begin
        m_full[k] = 0;
      end
    end
    #1;
    check_state({tag, "_post"});
    $display("step %-10s rst=%0d v=%0d sel=%0d data=%h ordy=%h acc=%0d out_valid=%h",
             tag, r, v, sel, dat, ordy, acc, out_valid);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin m_data[k] = '0; m_full[k] = 0; end
    rst = 1; in_valid = 0; {s2, s1, s0} = 3'd0; in_data = '0; out_ready = '0;
    @(posedge clk); #1;

    // Reset for two cycles, then idle with every select value.
    step(1, 0, 0, '0, 8'h00, "reset");
    step(1, 0, 0, '0, 8'h00, "reset");
    for (int k = 0; k < 8; k++) step(0, 0, k, '0, 8'h00, "idle");

    // Routing sweep with consumers stalled.
    for (int k = 0; k < 8; k++) step(0, 1, k, 32'h1000_0000 + k, 8'h00, "sweep");
    check("sweep_full", {24'h0, out_valid}, 32'h0000_00FF);

    // Backpressure on channel c while f still accepts.
    step(0, 0, 0, '0, 8'hFF, "drain");
    step(0, 1, 2, 32'hDEAD_BEEF, 8'h00, "fill_c");
    step(0, 1, 2, 32'h1234_5678, 8'h00, "bp_c");
    check("bp_c_hold", c, 32'hDEAD_BEEF);
    step(0, 1, 5, 32'h5555_0005, 8'h00, "bp_f");

    // Simultaneous drain and refill of h, then a four-word stream.
    step(0, 1, 7, 32'hA, 8'h00, "fill_h");
    step(0, 1, 7, 32'hB, 8'h80, "refill_h");
    check("refill_h_data", h, 32'hB);
    for (int i = 0; i < 4; i++) step(0, 1, 7, 32'hC0 + i, 8'h80, "stream_h");

    // Reset with pending words 8'h5A, producer and all consumers active.
    step(0, 0, 0, '0, 8'hFF, "drain");
    step(0, 1, 1, 32'h11, 8'h00, "fill5a");
    step(0, 1, 3, 32'h33, 8'h00, "fill5a");
    step(0, 1, 4, 32'h44, 8'h00, "fill5a");
    step(0, 1, 6, 32'h66, 8'h00, "fill5a");
    check("pending_5a", {24'h0, out_valid}, 32'h0000_005A);
    step(1, 1, 4, 32'hFFFF_FFFF, 8'hFF, "mid_rst");

    // Idle producer with varying select and data.
    for (int k = 0; k < 8; k++) step(0, 1, k, 32'h7700 + k, 8'h00, "refill");
    for (int k = 0; k < 8; k++) step(0, 0, k, $urandom, 8'h00, "idle_in");

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 40) == 0), $urandom_range(0, 1), $urandom_range(0, 7),
           $urandom, 8'($urandom), "random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1x8_wb.md
Name: demux_1x8_wb

Overview:
- Registered 1-to-8 demultiplexer with a valid/ready handshake on every channel. It is the distribution-side counterpart to the 8-way source-select mux.
- Takes one N-bit word plus a 3-bit select (s2,s1,s0), and delivers the word to exactly one of eight destination channels, a..h.
- Each destination has a one-entry holding register, so a stalled consumer blocks only its own channel.
- Used on the CPU write-back/result path to fan a single producer out to up to eight consumers (register-bank ports, forwarding latches, I/O).

Parameters:
- N, 32, data width of the input word and of each destination channel.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_data, input, N: word to distribute.
- s0, input, 1: select bit 0 (LSB).
- s1, input, 1: select bit 1.
- s2, input, 1: select bit 2 (MSB). Channel index idx = {s2,s1,s0}; 0=a, 1=b, ... 7=h.
- in_valid, input, 1: producer has a word and a select.
- in_ready, output, 1: the block accepts the word this cycle.
- a, b, c, d, e, f, g, h, output, N each: holding-register contents of channels 0..7.
- out_valid, output, 8: bit k = channel k holds an undelivered word.
- out_ready, input, 8: bit k = consumer k takes channel k's word this cycle.
- busy, output, 1: OR of out_valid.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid is cleared to 8'h00.
  - Channel registers a..h are cleared to 0.
  - While rst=1, in_ready=0 and no transfer occurs.
- Reset mid-operation discards all pending words without delivering them. No drain handshake fires in a cycle where rst=1.
- in_ready is combinational: !rst && (!out_valid[idx] || out_ready[idx]). It depends only on the selected channel; the other channels' state is irrelevant.
- Accept: in_valid && in_ready at an edge causes:
  - channel[idx] <= in_data;
  - out_valid[idx] <= 1.
- Latency: a word is visible on its channel output, with valid high, exactly 1 cycle after acceptance. There is no combinational path from in_data to channel outputs.
- Drain: out_valid[k] && out_ready[k] at an edge clears out_valid[k], unless channel k is refilled in the same cycle.
- Simultaneous drain and refill of the same channel: out_valid stays 1 and the register takes the new word. This sustains full throughput of 1 word/cycle per channel.
- Drain of channel j concurrent with accept into channel k≠j: both happen independently.
- Hold rule: while out_valid[k]=1 and out_ready[k]=0, channel k's data must not change.
- Unselected channels are never written. Their data and valid bits are only affected by their own out_ready.
- out_ready[k] while out_valid[k]=0 has no effect.
- Producer rule: in_data and s0..s2 stay stable while in_valid=1 && in_ready=0. If the select changes anyway, the block evaluates the current select only, with no error flag; a word goes to at most one channel per cycle.
- in_valid=0: no write regardless of select or in_ready.
- busy = |out_valid. It is registered-derived and deasserts in the cycle after the last drain.
- No reordering per channel; each channel holds at most one word.

Test Plan:
- Reset, then idle: rst=1 for 2 cycles, then 0. Required: out_valid=8'h00, a..h=0, busy=0, in_ready=1 for any select.
- Single routing sweep: with out_ready=8'h00, send in_data=32'h1000_0000+k with {s2,s1,s0}=k for k=0..7 on consecutive cycles. Required:
  - channel k equals 32'h1000_000k one cycle after its send;
  - out_valid fills 01,03,...,FF;
  - no other channel is disturbed.
- Backpressure on one channel: channel c (idx 2) is full with 32'hDEAD_BEEF and out_ready[2]=0; send 32'h1234_5678 to idx 2. Required:
  - in_ready=0 and the word is not accepted;
  - c holds DEAD_BEEF;
  - a send to idx 5 (f) in the same state is accepted.
- Drain and refill same cycle: channel h valid with 32'hA; out_ready[7]=1 and in_valid=1 with idx 7, data 32'hB. Required:
  - in_ready=1;
  - next cycle out_valid[7]=1 and h=32'hB;
  - streaming 4 words gives 4 consecutive deliveries.
- Reset mid-operation: out_valid=8'h5A with pending data; assert rst for one cycle while in_valid=1 and out_ready=8'hFF. Required:
  - no accept;
  - next cycle out_valid=00, all channels 0, busy=0.
- Idle input: in_valid=0 with select toggling 0..7 and in_data varying for 8 cycles. Required: out_valid and a..h unchanged.
